rom_loader: RTL

- Boot sequencer for the Hack computer. Receives a program image as a byte stream from the UART receiver and writes it word-by-word into the 16-bit instruction memory.
- Holds the CPU in reset while loading and releases it only after a complete, valid image has been written.
- Sits between the UART RX path and the instruction-memory write port. Its `cpu_reset` output drives the computer's CPU reset input.

---
 rtl/rom_loader.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rom_loader: boot sequencer that loads a Hack program image from a UART
// byte stream into instruction memory and holds the CPU in reset until done.
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, 2*LEN data bytes (big-endian words),
// plus one XOR checksum byte when ROM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   clk, reset (sync, active-low)        : clock / reset
//   rx_data, rx_valid                    : UART byte stream in
//   start                                : pulse to re-enter load mode
//   wr_en, wr_addr, wr_data              : instruction-memory write port
//   cpu_reset                            : active-high CPU reset
//   busy, done, error                    : frame / loaded / aborted status
module rom_loader #(
  parameter int          ADDR_WIDTH     = 15,
  parameter int          TIMEOUT_CYCLES = 27000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  start,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   MAX_LEN = 32'(2 ** ADDR_WIDTH);

  typedef enum logic [3:0] {
    S_WAIT_SYNC,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef ROM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_FLUSH,
    S_RUN,
    S_ERROR
  } state_t;

  state_t          r_state;
  logic [15:0]     r_len;
  logic [7:0]      r_hi;
  logic [CW-1:0]   r_cnt;
  logic [TW-1:0]   r_tmo;
  logic            r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [15:0]     r_wr_data;
  logic            r_cpu_reset;
  logic            r_busy;
  logic            r_done;
  logic            r_error;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]      r_chk;
`endif

  logic [15:0]     w_len;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_last;
  logic            w_wait;
  logic            w_sync;

  assign w_len     = {r_len[15:8], rx_data};
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_last    = 32'(w_cnt_nxt) == 32'(r_len);
  assign w_sync    = rx_valid && (rx_data == SYNC_BYTE);

  // States that are waiting for a byte inside a frame.
  always_comb begin
    w_wait = 1'b0;
    case (r_state)
      S_LEN_HI, S_LEN_LO,
      S_DATA_HI, S_DATA_LO: w_wait = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CHK:                w_wait = 1'b1;
`endif
      default:              w_wait = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_WAIT_SYNC;
      r_len       <= '0;
      r_hi        <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_chk       <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (w_wait && !rx_valid) begin
        // Idle inside a frame: count toward abort.
        if (r_tmo == TMO_MAX) begin
          r_state <= S_ERROR;
          r_busy  <= 1'b0;
          r_error <= 1'b1;
          r_tmo   <= '0;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end else begin
        r_tmo <= '0;
        case (r_state)
          S_WAIT_SYNC: begin
            if (w_sync) begin
              r_state <= S_LEN_HI;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
              r_chk   <= '0;
`endif
            end
          end
          S_LEN_HI: begin
            r_len[15:8] <= rx_data;
            r_state     <= S_LEN_LO;
          end
          S_LEN_LO: begin
            r_len[7:0] <= rx_data;
            if (32'(w_len) > MAX_LEN) begin
              r_state <= S_ERROR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end else if (w_len == 16'h0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_FLUSH;
`endif
            end else begin
              r_state <= S_DATA_HI;
            end
          end
          S_DATA_HI: begin
            r_hi    <= rx_data;
            r_state <= S_DATA_LO;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_chk   <= r_chk ^ rx_data;
`endif
          end
          S_DATA_LO: begin
            r_wr_en   <= 1'b1;
            r_wr_data <= {r_hi, rx_data};
            r_wr_addr <= r_cnt[ADDR_WIDTH-1:0];
            r_cnt     <= w_cnt_nxt;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_chk     <= r_chk ^ rx_data;
`endif
            if (w_last) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_FLUSH;
`endif
            end else begin
              r_state <= S_DATA_HI;
            end
          end
`ifdef ROM_LOADER_CHECKSUM_EN
          S_CHK: begin
            if (rx_data == r_chk) begin
              r_state <= S_FLUSH;
            end else begin
              r_state <= S_ERROR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end
          end
`endif
          // Lets the final write land before the CPU leaves reset.
          S_FLUSH: begin
            r_state     <= S_RUN;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_cpu_reset <= 1'b0;
          end
          S_RUN: begin
            if (start) begin
              r_state     <= S_WAIT_SYNC;
              r_cpu_reset <= 1'b1;
              r_done      <= 1'b0;
            end
          end
          S_ERROR: begin
            if (start) begin
              r_state <= S_WAIT_SYNC;
              r_error <= 1'b0;
            end else if (w_sync) begin
              r_state <= S_LEN_HI;
              r_busy  <= 1'b1;
              r_error <= 1'b0;
              r_cnt   <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
              r_chk   <= '0;
`endif
            end
          end
          default: r_state <= S_WAIT_SYNC;
        endcase
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign cpu_reset = r_cpu_reset;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule
